// File: rtl/imm_decode_stage_if.sv
// ---------------------------------------------------------------------------
// imm_decode_stage_if
// Bundles the fetch-side and execute-side handshakes of the immediate decode
// stage, plus the synchronous flush.
//   in_valid/in_ready/in_instr : instruction stream from fetch
//   flush                      : kill everything held and arriving this cycle
//   out_valid/out_ready        : decoded entry stream toward execute
//   out_instr/out_imm/out_fmt/out_illegal : payload of the presented entry
// Modports: slave = the decode stage, master = whoever drives/consumes it.
// ---------------------------------------------------------------------------
interface imm_decode_stage_if #(
  parameter int DATA_W = 64
) ();
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [DATA_W-1:0] out_imm;
  logic [2:0]        out_fmt;
  logic              out_illegal;

  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, out_instr, out_imm, out_fmt, out_illegal
  );

  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_decode_stage.sv
// ---------------------------------------------------------------------------
// imm_decode_stage
// Decodes the immediate field of a LEGv8 instruction word and hands the
// result to execute through a 2-entry (output register + skid register)
// in-order buffer.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : imm_decode_stage_if.slave (handshakes, payload, flush)
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high on that side. in_ready is registered and depends only on whether the
// skid entry is occupied; out payload is stable while out_valid & !out_ready.
// flush discards both held entries and any input offered in the same cycle,
// and no output transfer is considered to happen in a flush cycle.
// ---------------------------------------------------------------------------
module imm_decode_stage #(
  parameter int DATA_W = 64
) (
  input logic                clk,
  input logic                reset,
  imm_decode_stage_if.slave  bus
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_B     = 3'd1;
  localparam logic [2:0] FMT_CB    = 3'd2;
  localparam logic [2:0] FMT_D     = 3'd3;
  localparam logic [2:0] FMT_I     = 3'd4;
  localparam logic [2:0] FMT_IW    = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  typedef struct packed {
    logic [31:0]       instr;
    logic [DATA_W-1:0] imm;
    logic [2:0]        fmt;
    logic              illegal;
  } entry_t;

  entry_t dec;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   accept;
  logic   out_fire;

  // Combinational decode of the incoming word; opcode matches are exclusive.
  always_comb begin
    logic [31:0] i;
    i           = bus.in_instr;
    dec.instr   = i;
    dec.fmt     = FMT_NONE;
    dec.imm     = '0;
    if (i[31:26] == 6'b000101 || i[31:26] == 6'b100101) begin
      dec.fmt = FMT_B;
      dec.imm = {{36{i[25]}}, i[25:0], 2'b00};
    end else if (i[31:24] == 8'b10110100 || i[31:24] == 8'b10110101 ||
                 i[31:24] == 8'b01010100) begin
      dec.fmt = FMT_CB;
      dec.imm = {{43{i[23]}}, i[23:5], 2'b00};
    end else if (i[31:21] == 11'b11111000010 || i[31:21] == 11'b11111000000) begin
      dec.fmt = FMT_D;
      dec.imm = {{55{i[20]}}, i[20:12]};
    end else if (i[31:22] == 10'b1001000100 || i[31:22] == 10'b1101000100 ||
                 i[31:22] == 10'b1001001000 || i[31:22] == 10'b1011001000) begin
      dec.fmt = FMT_I;
      dec.imm = {52'd0, i[21:10]};
    end else if (i[31:23] == 9'b110100101 || i[31:23] == 9'b111100101) begin
      dec.fmt = FMT_IW;
      // instr[22:21] selects which 16-bit halfword receives the field.
      dec.imm = {48'd0, i[20:5]} << {i[22:21], 4'b0000};
    end else if (i[31:21] == 11'b11010011011 || i[31:21] == 11'b11010011010) begin
      dec.fmt = FMT_SHAMT;
      dec.imm = {58'd0, i[15:10]};
    end
    dec.illegal = (dec.fmt == FMT_NONE);
  end

  assign accept   = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  // Buffer control. The skid entry only fills while the output register is
  // stalled, and since in_ready is low whenever skid is full, an accept and
  // an occupied skid never coincide.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (bus.flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_fire) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_instr   = out_q.instr;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_fmt     = out_q.fmt;
  assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;

  localparam int EW = 100;  // {instr 32, imm 64, fmt 3, illegal 1}

  // Opcode table: prefix width, prefix value, format code.
  localparam int OP_W[15]   = '{6, 6, 8, 8, 8, 11, 11, 10, 10, 10, 10, 9, 9, 11, 11};
  localparam int OP_PAT[15] = '{'b000101, 'b100101,
                                'b10110100, 'b10110101, 'b01010100,
                                'b11111000010, 'b11111000000,
                                'b1001000100, 'b1101000100, 'b1001001000, 'b1011001000,
                                'b110100101, 'b111100101,
                                'b11010011011, 'b11010011010};
  localparam int OP_FMT[15] = '{1, 1, 2, 2, 2, 3, 3, 4, 4, 4, 4, 5, 5, 6, 6};

  logic clk;
  logic reset;
  imm_decode_stage_if #(.DATA_W(64)) bus ();

  imm_decode_stage #(.DATA_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic          mon_en = 1'b0;
  logic          held_valid = 1'b0;
  logic [EW-1:0] held_ent;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint ufield(input logic [31:0] w, input int hi, input int lo);
    longint n;
    n = hi - lo + 1;
    return (longint'(w) >> lo) & ((longint'(1) << n) - 1);
  endfunction

  function automatic longint sfield(input logic [31:0] w, input int hi, input int lo);
    longint n, v;
    n = hi - lo + 1;
    v = ufield(w, hi, lo);
    if (v >= (longint'(1) << (n - 1))) v = v - (longint'(1) << n);
    return v;
  endfunction

  function automatic logic [EW-1:0] model(input logic [31:0] w);
    int     fmt;
    longint imm;
    fmt = 0;
    imm = 0;
    for (int k = 0; k < 15; k++)
      if ((w >> (32 - OP_W[k])) == 32'(OP_PAT[k])) fmt = OP_FMT[k];
    case (fmt)
      1: imm = sfield(w, 25, 0) * 4;
      2: imm = sfield(w, 23, 5) * 4;
      3: imm = sfield(w, 20, 12);
      4: imm = ufield(w, 21, 10);
      5: imm = ufield(w, 20, 5) * (longint'(1) << (16 * ufield(w, 22, 21)));
      6: imm = ufield(w, 15, 10);
      default: imm = 0;
    endcase
    return {w, 64'(imm), 3'(fmt), (fmt == 0)};
  endfunction

  function automatic logic [31:0] rand_instr();
    int k;
    int w;
    if ($urandom_range(0, 9) < 8) begin
      k = $urandom_range(0, 14);
      w = OP_W[k];
      return (32'(OP_PAT[k]) << (32 - w)) | ($urandom() & ((32'd1 << (32 - w)) - 32'd1));
    end
    return $urandom();
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      held_valid = 1'b0;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    end else if (mon_en) begin
      logic [EW-1:0] e;
      chk("in_ready_occ", 64'(bus.in_ready), 64'(exp_q.size() < 2));
      chk("out_valid_occ", 64'(bus.out_valid), 64'(exp_q.size() > 0));
      if (held_valid) begin
        chk("stall_stable", {bus.out_instr, 32'(bus.out_fmt)} ^ 64'(bus.out_illegal),
            {held_ent[99:68], 32'(held_ent[3:1])} ^ 64'(held_ent[0]));
        chk("stall_imm", bus.out_imm, held_ent[67:4]);
      end
      if (bus.flush) begin
        exp_q.delete();
        held_valid = 1'b0;
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 64'(bus.out_instr), 64'hDEAD_DEAD_DEAD_DEAD);
          end else begin
            e = exp_q.pop_front();
            chk("out_instr", 64'(bus.out_instr), 64'(e[99:68]));
            chk("out_imm", bus.out_imm, e[67:4]);
            chk("out_fmt", 64'(bus.out_fmt), 64'(e[3:1]));
            chk("out_illegal", 64'(bus.out_illegal), 64'(e[0]));
          end
        end
        held_valid = bus.out_valid && !bus.out_ready;
        held_ent   = {bus.out_instr, bus.out_imm, bus.out_fmt, bus.out_illegal};
        if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_instr));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_check(input logic [31:0] w, input logic [2:0] f,
                            input logic [63:0] imm, input logic ill);
    bus.in_valid  = 1'b1;
    bus.in_instr  = w;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("dir_valid", 64'(bus.out_valid), 64'd1);
    chk("dir_fmt", 64'(bus.out_fmt), 64'(f));
    chk("dir_imm", bus.out_imm, imm);
    chk("dir_illegal", 64'(bus.out_illegal), 64'(ill));
  endtask

  task automatic fill_two();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = rand_instr();
    step();
    bus.in_instr  = rand_instr();
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic got;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_imm", bus.out_imm, 64'd0);
    chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
    #2 reset = 1'b1;
    step();
    chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
    mon_en = 1'b1;

    // Known decode vectors, one cycle latency from an empty stage.
    send_check(32'h17FF_FFFF, 3'd1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send_check(32'hF85F_F000, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send_check(32'h913F_FC00, 3'd4, 64'h0000_0000_0000_0FFF, 1'b0);
    send_check(32'hD2F5_79A0, 3'd5, 64'hABCD_0000_0000_0000, 1'b0);
    send_check(32'h0000_0000, 3'd0, 64'd0, 1'b1);
    step();

    // Backpressure: A, B held, C waits, then all three drain in order.
    fill_two();
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_instr = rand_instr();
    step();
    step();
    bus.out_ready = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      got = bus.in_ready;
      step();
    end
    chk("c_accepted", 64'(got), 64'd1);
    bus.in_valid = 1'b0;
    repeat (4) step();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    // Flush with both entries full and an input offered.
    fill_two();
    bus.in_instr = rand_instr();
    bus.flush    = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    repeat (4) step();

    // Reset mid-cycle with two entries held.
    fill_two();
    bus.in_valid = 1'b0;
    #2 reset = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_ready", 64'(bus.in_ready), 64'd0);
    chk("mid_rst_imm", bus.out_imm, 64'd0);
    chk("mid_rst_misc", {bus.out_instr, 29'd0, bus.out_fmt} | 64'(bus.out_illegal), 64'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    step();
    chk("mid_rel_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rel_valid", 64'(bus.out_valid), 64'd0);
    mon_en = 1'b1;
    bus.out_ready = 1'b1;
    repeat (4) step();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_instr  = rand_instr();
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.flush     = ($urandom_range(0, 99) < 3);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) step();
    chk("final_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
